fft_out_unpacker: RTL and testbench

//  Sink side of the topfft 4-lane output interface. Each valid cycle it captures

---
 rtl/fft_out_unpacker.sv | 103 ++++++++++
 tb/tb_fft_out_unpacker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_unpacker.sv
// Buffers 4-lane topfft output words and replays them as a framed serial stream.
// Define FFTOUT_OVF_STICKY_EN to make overflow sticky until reset.
module fft_out_unpacker #(
  parameter int NBITS_out = 21,
  parameter int N         = 128,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [2*NBITS_out-1:0]     fftOut0_up,
  input  logic [2*NBITS_out-1:0]     fftOut0_down,
  input  logic [2*NBITS_out-1:0]     fftOut1_up,
  input  logic [2*NBITS_out-1:0]     fftOut1_down,
  output logic [2*NBITS_out-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sof,
  output logic                       out_eof,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int unsigned W  = 2 * NBITS_out;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(N);
  localparam logic [LW-1:0] FULL     = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [4*W-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [LW-1:0]  r_level;
  logic [1:0]     r_lane;
  logic [CW-1:0]  r_cnt;
  logic           r_ovf;

  logic           w_valid;
  logic           w_xfer;
  logic           w_pop;
  logic           w_wr;
  logic           w_drop;
  logic [4*W-1:0] w_head;
  logic [W-1:0]   w_sel;

  always_comb begin
    w_valid = (r_level != '0);
    w_xfer  = w_valid & out_ready;
    w_pop   = w_xfer & (r_lane == 2'd3);
    // a pop frees the head slot at the same edge, so a full FIFO still accepts
    w_wr    = in_valid & ((r_level != FULL) | w_pop);
    w_drop  = in_valid & ~w_wr;
    w_head  = r_mem[r_rptr];
    w_sel   = '0;
    case (r_lane)
      2'd0:    w_sel = w_head[0*W +: W];
      2'd1:    w_sel = w_head[1*W +: W];
      2'd2:    w_sel = w_head[2*W +: W];
      default: w_sel = w_head[3*W +: W];
    endcase
  end

  assign out_valid = w_valid;
  assign out_data  = w_valid ? w_sel : '0;
  assign out_sof   = w_valid & (r_cnt == '0);
  assign out_eof   = w_valid & (r_cnt == CNT_LAST);
  assign level     = r_level;
  assign overflow  = r_ovf;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {fftOut1_down, fftOut1_up, fftOut0_down, fftOut0_up};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_lane  <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_xfer) begin
        r_lane <= r_lane + 2'd1;
        r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
`ifdef FFTOUT_OVF_STICKY_EN
      r_ovf <= r_ovf | w_drop;
`else
      r_ovf <= w_drop;
`endif
    end
  end

endmodule

// File: tb/tb_fft_out_unpacker.sv
// Directed self-checking bench for fft_out_unpacker (default parameters).
module tb_fft_out_unpacker;

  localparam int NB = 21;
  localparam int W  = 2 * NB;
`ifdef FFTOUT_OVF_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] l0, l1, l2, l3;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sof;
  logic         out_eof;
  logic [2:0]   level;
  logic         overflow;

  int n_chk  = 0;
  int n_fail = 0;

  fft_out_unpacker #(.NBITS_out(NB), .N(128), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .fftOut0_up   (l0),
    .fftOut0_down (l1),
    .fftOut1_up   (l2),
    .fftOut1_down (l3),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sof      (out_sof),
    .out_eof      (out_eof),
    .level        (level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] smp(input int re, input int im);
    return {NB'(re), NB'(im)};
  endfunction

  // word w, lane l carries re = 100+4w+l, im = 4w+l
  task automatic drive_word(input int w);
    l0 = smp(100 + 4*w + 0, 4*w + 0);
    l1 = smp(100 + 4*w + 1, 4*w + 1);
    l2 = smp(100 + 4*w + 2, 4*w + 2);
    l3 = smp(100 + 4*w + 3, 4*w + 3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int sent, got, n;
    logic         held_v;
    logic [W-1:0] held_d;

    // 1: reset with random activity on the inputs
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    l0 = '0; l1 = '0; l2 = '0; l3 = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'(($urandom & 1));
      out_ready = 1'(($urandom & 1));
      l0 = W'({$urandom, $urandom}); l1 = W'({$urandom, $urandom});
      l2 = W'({$urandom, $urandom}); l3 = W'({$urandom, $urandom});
      chk("t1_rst_valid", out_valid, 0);
      chk("t1_rst_data", out_data, 0);
      chk("t1_rst_sof", out_sof, 0);
      chk("t1_rst_eof", out_eof, 0);
      chk("t1_rst_level", level, 0);
      chk("t1_rst_ovf", overflow, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t1_idle_valid", out_valid, 0);
      chk("t1_idle_level", level, 0);
    end

    // 2: single word, re 1..4
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    l0 = smp(1, 0); l1 = smp(2, 0); l2 = smp(3, 0); l3 = smp(4, 0);
    for (int l = 0; l < 4; l++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk("t2_valid", out_valid, 1);
      chk("t2_data", out_data, smp(l + 1, 0));
      chk("t2_sof", out_sof, (l == 0));
      chk("t2_level", level, 1);
    end
    @(negedge clk);
    chk("t2_level_end", level, 0);
    chk("t2_valid_end", out_valid, 0);

    // 3: 8 words with out_ready toggling
    do_reset();
    sent = 0; got = 0; held_v = 1'b0; held_d = '0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (held_v) begin
        chk("t3_hold_valid", out_valid, 1);
        chk("t3_hold_data", out_data, held_d);
      end
      in_valid = (c % 8 == 0) && (sent < 8);
      if (in_valid) begin
        drive_word(sent);
        sent++;
      end
      out_ready = (c % 2 == 0);
      if (out_valid && out_ready) begin
        chk("t3_data", out_data, smp(100 + got, got));
        chk("t3_sof", out_sof, (got == 0));
        got++;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
    end
    chk("t3_count", got, 32);
    chk("t3_level_end", level, 0);

    // 4: overflow with consumer stalled
    do_reset();
    for (int w = 1; w <= 5; w++) begin
      @(negedge clk);
      chk("t4_fill_level", level, w - 1);
      chk("t4_fill_ovf", overflow, 0);
      in_valid = 1'b1; out_ready = 1'b0;
      l0 = smp(10*w + 0, 0); l1 = smp(10*w + 1, 0);
      l2 = smp(10*w + 2, 0); l3 = smp(10*w + 3, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("t4_full_level", level, 4);
    chk("t4_ovf", overflow, 1);
    @(negedge clk);
    chk("t4_ovf_after", overflow, STICKY);
    chk("t4_level_hold", level, 4);
    for (int w = 1; w <= 4; w++) begin
      for (int l = 0; l < 4; l++) begin
        @(negedge clk);
        out_ready = 1'b1;
        chk("t4_drain_valid", out_valid, 1);
        chk("t4_drain_data", out_data, smp(10*w + l, 0));
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("t4_empty_valid", out_valid, 0);
    chk("t4_empty_level", level, 0);
    chk("t4_ovf_end", overflow, STICKY);

    // 5: two full frames of 128 samples
    do_reset();
    sent = 0; got = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      in_valid = (c % 4 == 0) && (sent < 64);
      if (in_valid) begin
        drive_word(sent);
        sent++;
      end
      out_ready = 1'b1;
      if (out_valid) begin
        chk("t5_data", out_data, smp(100 + got, got));
        chk("t5_sof", out_sof, (got % 128 == 0));
        chk("t5_eof", out_eof, (got % 128 == 127));
        got++;
      end
    end
    chk("t5_count", got, 256);
    chk("t5_ovf", overflow, 0);

    // 6: reset in the middle of a frame
    do_reset();
    n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      @(negedge clk);
      in_valid = (c < 4);
      drive_word(c);
      out_ready = 1'b1;
      if (out_valid) n++;
    end
    chk("t6_xfers", n, 10);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t6_level_pre", level, 2);
    chk("t6_data_pre", out_data, smp(110, 10));
    rst = 1'b0;
    #1;
    chk("t6_rst_level", level, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    drive_word(20);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6_new_valid", out_valid, 1);
    chk("t6_new_sof", out_sof, 1);
    chk("t6_new_data", out_data, smp(180, 80));
    chk("t6_new_level", level, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
